// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, types and round helper functions for the
// iterative SHA-256 compressor.
//   - state_t : controller state encoding (IDLE/RUN/FINAL/DONE)
//   - K       : 64 round constants
//   - IV256   : SHA-256 initial hash value, H0 in [255:224]
//   - IV224   : SHA-224 initial hash value (only with SHA256_CORE_SHA224_EN)
//   - rotr, big_sigma0/1, small_sigma0/1, ch, maj, iv_word
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA256_CORE_SHA224_EN
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word i of a packed 8-word hash value; word 0 sits in the top 32 bits.
  function automatic logic [31:0] iv_word(input logic [255:0] iv, input int i);
    return iv[255-32*i -: 32];
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16 x 32-bit message schedule window.
// The window always holds W[t..t+15]. On load it is filled from the padded
// block (W0 = block_in[511:480]); on advance it shifts by UNROLL words and
// the UNROLL new tail words W[t+16..] are computed from the window.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        fill window from block_in
//   advance     shift window by UNROLL words
//   block_in    512-bit padded block
//   w_out       W[t+j] in w_out[32*j +: 32], j = 0..UNROLL-1
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [511:0]          block_in,
  output logic [UNROLL*32-1:0]  w_out
);

  logic [31:0] win_q [16];
  // Window extended by the UNROLL words that follow it. New words may depend
  // on earlier new words (W[t+18] uses W[t+16]) when UNROLL > 2.
  logic [31:0] ext [16+UNROLL];

  always_comb begin
    for (int i = 0; i < 16 + UNROLL; i++) ext[i] = '0;
    for (int i = 0; i < 16; i++) ext[i] = win_q[i];
    for (int j = 0; j < UNROLL; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_wout
    assign w_out[32*j +: 32] = win_q[j];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win_q[i] <= block_in[511-32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 16; i++) win_q[i] <= ext[i+UNROLL];
    end
  end

endmodule

// File: rtl/sha256_core_iter.sv
// sha256_core_iter: iterative SHA-256 block compressor, UNROLL rounds/clock.
// Optional feature macro: SHA256_CORE_SHA224_EN adds the mode224 input and
// SHA-224 IV selection with digest[31:0] forced to zero.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. Input side: in_ready is 1 only in IDLE, so one block
// is in flight at a time. Output side: once out_valid rises, out_valid and
// digest hold until the edge where out_ready is 1; out_ready alone is ignored.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  input handshake for block_in/first (and mode224)
//   block_in           padded 512-bit block, W0 in [511:480]
//   first              1: start from IV, 0: chain from the previous result
//   mode224            (macro only) select SHA-224 IV when first=1
//   out_valid/out_ready output handshake for digest
//   digest             H0 in [255:224] .. H7 in [31:0]
//   dbg_state          current controller state (state_t encoding)
module sha256_core_iter
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  block_in,
  input  logic          first,
`ifdef SHA256_CORE_SHA224_EN
  input  logic          mode224,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [255:0]  digest,
  output logic [1:0]    dbg_state
);

  localparam int CYC = 64 / UNROLL;
  // Round index held during the last RUN cycle.
  localparam logic [6:0] LAST_T = 7'(UNROLL * (CYC - 1));

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_core_iter: UNROLL must be 1, 2, 4 or 8");
  end

  state_t               state_q, state_d;
  logic                 accept;
  logic [6:0]           round_q;
  logic [31:0]          work_q [8];
  logic [31:0]          work_d [8];
  logic [31:0]          h_q [8];
  logic [31:0]          h_sum [8];
  logic [255:0]         digest_q;
  logic [255:0]         digest_next;
  logic [255:0]         iv_first;
  logic [UNROLL*32-1:0] w_cur;

  assign accept = in_valid && in_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (round_q == LAST_T) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Gated by rst_n so the core never advertises ready while reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    dbg_state = state_q;
  end

  // ---------------- message schedule ----------------
  sha256_msg_sched #(.UNROLL(UNROLL)) u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .advance  (state_q == S_RUN),
    .block_in (block_in),
    .w_out    (w_cur)
  );

  // ---------------- IV selection ----------------
`ifdef SHA256_CORE_SHA224_EN
  logic mode224_q;
  assign iv_first = mode224 ? IV224 : IV256;
`else
  assign iv_first = IV256;
`endif

  // ---------------- round datapath ----------------
  // work[0..7] = a..h. UNROLL rounds are chained in one cycle.
  always_comb begin : round_logic
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  kidx;
    for (int i = 0; i < 8; i++) work_d[i] = work_q[i];
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int j = 0; j < UNROLL; j++) begin
      kidx = round_q[5:0] + 6'(j);
      t1 = work_d[7] + big_sigma1(work_d[4]) + ch(work_d[4], work_d[5], work_d[6])
         + K[kidx] + w_cur[32*j +: 32];
      t2 = big_sigma0(work_d[0]) + maj(work_d[0], work_d[1], work_d[2]);
      work_d[7] = work_d[6];
      work_d[6] = work_d[5];
      work_d[5] = work_d[4];
      work_d[4] = work_d[3] + t1;
      work_d[3] = work_d[2];
      work_d[2] = work_d[1];
      work_d[1] = work_d[0];
      work_d[0] = t1 + t2;
    end
  end

  // Feed-forward sum and the value presented as the digest.
  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + work_q[i];
    digest_next = {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                   h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
`ifdef SHA256_CORE_SHA224_EN
    // Truncation applies to the output only; h_q keeps the full word for chaining.
    if (mode224_q) digest_next[31:0] = '0;
`endif
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_q   <= '0;
      out_valid <= 1'b0;
      digest_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        work_q[i] <= '0;
        h_q[i]    <= iv_word(IV256, i);
      end
`ifdef SHA256_CORE_SHA224_EN
      mode224_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            round_q <= '0;
            if (first) begin
              for (int i = 0; i < 8; i++) begin
                work_q[i] <= iv_word(iv_first, i);
                h_q[i]    <= iv_word(iv_first, i);
              end
`ifdef SHA256_CORE_SHA224_EN
              mode224_q <= mode224;
`endif
            end else begin
              for (int i = 0; i < 8; i++) work_q[i] <= h_q[i];
            end
          end
        end
        S_RUN: begin
          for (int i = 0; i < 8; i++) work_q[i] <= work_d[i];
          round_q <= round_q + 7'(UNROLL);
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
          digest_q  <= digest_next;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign digest = digest_q;

endmodule

// File: tb/tb_sha256_core_iter.sv
// tb_sha256_core_iter: directed bench for sha256_core_iter. Two instances
// share clock, reset and block/first inputs: u_dut1 (UNROLL=1) and
// u_dut8 (UNROLL=8). Known FIPS 180 vectors supply expected digests.
`timescale 1ns/1ps
module tb_sha256_core_iter;

  localparam logic [1:0] ST_IDLE = 2'd0;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_B = {448'h0, 64'h00000000000001c0};

  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_CORE_SHA224_EN
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [511:0] block_in = '0;
  logic         first = 1'b0;
  logic         in_valid_u [2];
  logic         out_ready_u [2];
  logic         in_ready_u [2];
  logic         out_valid_u [2];
  logic [255:0] digest_u [2];
  logic [1:0]   dbg_state_u [2];
`ifdef SHA256_CORE_SHA224_EN
  logic         mode224 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q [$];

  sha256_core_iter #(.UNROLL(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_u[0]),
    .in_ready  (in_ready_u[0]),
    .block_in  (block_in),
    .first     (first),
`ifdef SHA256_CORE_SHA224_EN
    .mode224   (mode224),
`endif
    .out_valid (out_valid_u[0]),
    .out_ready (out_ready_u[0]),
    .digest    (digest_u[0]),
    .dbg_state (dbg_state_u[0])
  );

  sha256_core_iter #(.UNROLL(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_u[1]),
    .in_ready  (in_ready_u[1]),
    .block_in  (block_in),
    .first     (first),
`ifdef SHA256_CORE_SHA224_EN
    .mode224   (mode224),
`endif
    .out_valid (out_valid_u[1]),
    .out_ready (out_ready_u[1]),
    .digest    (digest_u[1]),
    .dbg_state (dbg_state_u[1])
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [511:0] blk, input logic f);
    int n;
    n = 0;
    while (!in_ready_u[sel] && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_before_send", 256'(in_ready_u[sel]), 256'(1'b1));
    block_in = blk;
    first = f;
    in_valid_u[sel] = 1'b1;
    tick();
    in_valid_u[sel] = 1'b0;
  endtask

  // Waits for out_valid (bounded), checks latency and optionally the digest
  // against the head of the expected queue.
  task automatic wait_out(input int sel, input string tag, input int exp_lat, input bit chk_digest);
    int n;
    logic [255:0] e;
    n = 0;
    while (!out_valid_u[sel] && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 256'(n), 256'(exp_lat));
    if (chk_digest) begin
      if (exp_q.size() == 0) e = '1;
      else e = exp_q.pop_front();
      check({tag, "_digest"}, digest_u[sel], e);
    end
  endtask

  task automatic drain(input int sel, input string tag);
    out_ready_u[sel] = 1'b1;
    tick();
    out_ready_u[sel] = 1'b0;
    check({tag, "_ov_low"}, 256'(out_valid_u[sel]), 256'(1'b0));
    check({tag, "_idle"}, 256'(dbg_state_u[sel]), 256'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid_u[i]  = 1'b0;
      out_ready_u[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready_pre_edge", 256'(in_ready_u[i]), 256'(1'b0));
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", 256'(in_ready_u[i]), 256'(1'b0));
      check("reset_out_valid", 256'(out_valid_u[i]), 256'(1'b0));
      check("reset_digest", digest_u[i], 256'h0);
      check("reset_state", 256'(dbg_state_u[i]), 256'(ST_IDLE));
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("idle_in_ready", 256'(in_ready_u[i]), 256'(1'b1));
    end

    // 1: "abc", UNROLL=1, latency 65
    exp_q.push_back(D_ABC);
    send(0, BLK_ABC, 1'b1);
    wait_out(0, "abc_u1", 65, 1'b1);
    drain(0, "abc_u1");

    // out_ready without out_valid does nothing
    out_ready_u[0] = 1'b1;
    tick();
    out_ready_u[0] = 1'b0;
    check("stray_out_ready_ov", 256'(out_valid_u[0]), 256'(1'b0));
    check("stray_out_ready_state", 256'(dbg_state_u[0]), 256'(ST_IDLE));
    check("stray_out_ready_digest", digest_u[0], D_ABC);

    // 2: empty message, UNROLL=8, latency 9
    exp_q.push_back(D_EMPTY);
    send(1, BLK_EMPTY, 1'b1);
    wait_out(1, "empty_u8", 9, 1'b1);
    drain(1, "empty_u8");

    // 3: two-block message, second block chained
    send(1, BLK_TWO_A, 1'b1);
    wait_out(1, "two_blk1", 9, 1'b0);
    drain(1, "two_blk1");
    exp_q.push_back(D_TWO);
    send(1, BLK_TWO_B, 1'b0);
    wait_out(1, "two_blk2", 9, 1'b1);
    drain(1, "two_blk2");

    // 4: consumer stalls for 20 cycles with in_valid pulses
    exp_q.push_back(D_ABC);
    send(1, BLK_ABC, 1'b1);
    wait_out(1, "stall", 9, 1'b1);
    for (int k = 0; k < 20; k++) begin
      in_valid_u[1] = (k % 3 == 0);
      block_in = BLK_EMPTY;
      first = 1'b1;
      tick();
      check("stall_digest", digest_u[1], D_ABC);
      check("stall_out_valid", 256'(out_valid_u[1]), 256'(1'b1));
      check("stall_in_ready", 256'(in_ready_u[1]), 256'(1'b0));
    end
    in_valid_u[1] = 1'b0;
    drain(1, "stall");
    check("stall_digest_kept", digest_u[1], D_ABC);
    for (int k = 0; k < 12; k++) tick();
    check("stall_no_ghost_ov", 256'(out_valid_u[1]), 256'(1'b0));
    check("stall_no_ghost_state", 256'(dbg_state_u[1]), 256'(ST_IDLE));

    // 5: reset at round 30, then rerun "abc" with first=0
    send(0, BLK_ABC, 1'b1);
    for (int k = 0; k < 30; k++) tick();
    rst_n = 1'b0;
    tick();
    check("abort_out_valid", 256'(out_valid_u[0]), 256'(1'b0));
    check("abort_digest", digest_u[0], 256'h0);
    check("abort_state", 256'(dbg_state_u[0]), 256'(ST_IDLE));
    check("abort_in_ready", 256'(in_ready_u[0]), 256'(1'b0));
    rst_n = 1'b1;
    #1;
    check("abort_in_ready_after", 256'(in_ready_u[0]), 256'(1'b1));
    exp_q.push_back(D_ABC);
    send(0, BLK_ABC, 1'b0);
    wait_out(0, "rerun_first0", 65, 1'b1);
    drain(0, "rerun_first0");

`ifdef SHA256_CORE_SHA224_EN
    // 6: SHA-224 of "abc"
    mode224 = 1'b1;
    exp_q.push_back(D_ABC224);
    send(1, BLK_ABC, 1'b1);
    mode224 = 1'b0;
    wait_out(1, "sha224", 9, 1'b1);
    drain(1, "sha224");
`endif

    check("exp_q_empty", 256'(exp_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
